// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, with cycle ownership held
// until the owner drops cyc and a stall watchdog that aborts hung strobes.
module wb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]                m_dat_o,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic                                 s_cyc_o,
  output logic                                 s_stb_o,
  output logic                                 s_we_o,
  output logic [ADDR_WIDTH-1:0]                s_adr_o,
  output logic [DATA_WIDTH-1:0]                s_dat_o,
  output logic [DATA_WIDTH/8-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]                s_dat_i,
  input  logic                                 s_ack_i,
  input  logic                                 s_err_i,
  output logic [NUM_MASTERS-1:0]               grant_o,
  output logic                                 timeout_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                   state_r;
  logic [NUM_MASTERS-1:0]   grant_r;
  logic [IDX_W-1:0]         owner_r;
  logic [IDX_W-1:0]         rr_ptr_r;
  logic [CNT_W-1:0]         stall_cnt_r;

  logic                     pick_found_s;
  logic [IDX_W-1:0]         pick_idx_s;
  logic [NUM_MASTERS-1:0]   pick_onehot_s;
  logic [IDX_W-1:0]         next_ptr_s;
  logic                     owner_cyc_s;
  logic                     stall_s;

  assign owner_cyc_s = m_cyc_i[owner_r];
  assign m_dat_o     = s_dat_i;
  assign grant_o     = grant_r;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    int cand;
    pick_found_s  = 1'b0;
    pick_idx_s    = '0;
    pick_onehot_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (int'(rr_ptr_r) + i) % NUM_MASTERS;
      if (!pick_found_s && m_cyc_i[cand]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IDX_W'(cand);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    pick_onehot_s[pick_idx_s] = 1'b1;
  end

  // Pointer value taken on release: one past the departing owner.
  always_comb begin
    if (int'(owner_r) == NUM_MASTERS - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + IDX_W'(1);
    end
  end

  // Slave-side mux and response routing; only OWNED connects the owner through.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;
    case (state_r)
      OWNED: begin
        s_cyc_o          = owner_cyc_s;
        s_stb_o          = owner_cyc_s & m_stb_i[owner_r];
        s_we_o           = m_we_i[owner_r];
        s_adr_o          = m_adr_i[int'(owner_r)*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o          = m_dat_i[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o          = m_sel_i[int'(owner_r)*SEL_W +: SEL_W];
        m_ack_o[owner_r] = s_ack_i;
        m_err_o[owner_r] = s_err_i;
      end
      ABORT: begin
        m_err_o[owner_r] = 1'b1;
        timeout_o        = 1'b1;
      end
      IDLE, DRAIN: begin
        timeout_o = 1'b0;
      end
      default: begin
        timeout_o = 1'b0;
      end
    endcase
  end

  assign stall_s = (state_r == OWNED) && s_stb_o && !s_ack_i && !s_err_i;

  // Arbitration FSM with ownership, round-robin pointer and stall watchdog.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      owner_r     <= '0;
      rr_ptr_r    <= '0;
      stall_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          stall_cnt_r <= '0;
          if (pick_found_s) begin
            state_r <= OWNED;
            grant_r <= pick_onehot_s;
            owner_r <= pick_idx_s;
          end else begin
            state_r <= IDLE;
          end
        end
        OWNED: begin
          if (!owner_cyc_s) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= next_ptr_s;
            stall_cnt_r <= '0;
          end else if (stall_s && (stall_cnt_r == CNT_W'(TIMEOUT))) begin
            state_r     <= ABORT;
            stall_cnt_r <= '0;
          end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
          end else begin
            stall_cnt_r <= '0;
          end
        end
        ABORT: begin
          state_r     <= DRAIN;
          stall_cnt_r <= '0;
        end
        DRAIN: begin
          stall_cnt_r <= '0;
          if (!owner_cyc_s) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            rr_ptr_r <= next_ptr_s;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r     <= IDLE;
          grant_r     <= '0;
          stall_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
